// File: rtl/payload_serializer.sv
// Store-and-forward payload source: buffers one byte packet, publishes its bit
// length, then streams it as BPSK (1 bit/beat) or QPSK (2 bits/beat) symbols.
module payload_serializer #(
  parameter int BYTES = 1,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic               s_tlast,
  input  logic               s_tuser,
  output logic [BYTES*8-1:0] m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic               m_tuser,
  output logic [15:0]        payload_length,
  input  logic               pkt_sent,
  output logic               overflow,
  output logic               busy
);

  localparam int BITS = BYTES * 8;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [15:0]   DEPTH16   = 16'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_DROP, S_DRAIN, S_WAIT} state_t;

  state_t         state, state_nxt;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [15:0]    byte_count;
  logic [15:0]    rd_cnt;
  logic [15:0]    ld_cnt;
  logic [7:0]     rd_data;
  logic           rd_valid;
  logic [7:0]     sh;
  logic [2:0]     beat_cnt;
  logic           cur_last;
  logic           is_bpsk;
  logic           accept, wr_en, rd_en, load, hs, last_beat;

  assign accept    = s_tvalid && s_tready;
  assign wr_en     = accept && (state == S_IDLE || state == S_FILL);
  assign hs        = m_tvalid && m_tready;
  assign last_beat = (beat_cnt == (is_bpsk ? 3'd7 : 3'd3));
  // rd_data acts as a one-byte prefetch slot; it is refilled as soon as it is consumed
  assign load      = (state == S_DRAIN) && rd_valid && (!m_tvalid || (hs && last_beat));
  assign rd_en     = (state == S_DRAIN) && (rd_cnt < byte_count) && (!rd_valid || load);
  assign m_tuser   = is_bpsk;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = s_tlast ? S_DRAIN : S_FILL;
      S_FILL:  if (accept) begin
                 if (s_tlast)                  state_nxt = S_DRAIN;
                 else if (wr_ptr == LAST_ADDR) state_nxt = S_DROP;
               end
      S_DROP:  if (accept && s_tlast) state_nxt = S_DRAIN;
      S_DRAIN: if (hs && m_tlast) state_nxt = S_WAIT;
      S_WAIT:  if (pkt_sent) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    s_tready = !rst && (state == S_IDLE || state == S_FILL || state == S_DROP);
    busy     = (state != S_IDLE);
    m_tlast  = m_tvalid && cur_last && last_beat;
    m_tdata  = '0;
    if (is_bpsk) m_tdata = {BITS{sh[7]}};
    else         m_tdata[1:0] = sh[7:6];
  end

  // Buffer storage has no reset; contents are only read after being written
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s_tdata;
    if (rd_en) rd_data <= mem[rd_cnt[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      byte_count     <= '0;
      payload_length <= '0;
      overflow       <= 1'b0;
      is_bpsk        <= 1'b1;
      rd_cnt         <= '0;
      ld_cnt         <= '0;
      rd_valid       <= 1'b0;
      sh             <= '0;
      beat_cnt       <= '0;
      cur_last       <= 1'b0;
      m_tvalid       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          wr_ptr     <= AW'(1);
          is_bpsk    <= s_tuser;
          overflow   <= 1'b0;
          byte_count <= 16'd1;
          if (s_tlast) payload_length <= 16'd8;
        end
        S_FILL: if (accept) begin
          wr_ptr <= wr_ptr + AW'(1);
          if (s_tlast) begin
            byte_count     <= 16'(wr_ptr) + 16'd1;
            payload_length <= (16'(wr_ptr) + 16'd1) << 3;
          end else if (wr_ptr == LAST_ADDR) begin
            byte_count <= DEPTH16;
            overflow   <= 1'b1;
          end
        end
        S_DROP: begin
          wr_ptr <= '0;
          if (accept && s_tlast) payload_length <= byte_count << 3;
        end
        default: wr_ptr <= '0;
      endcase

      if (state == S_DRAIN) begin
        if (rd_en) rd_cnt <= rd_cnt + 16'd1;
        if (rd_en)     rd_valid <= 1'b1;
        else if (load) rd_valid <= 1'b0;
        if (load) begin
          sh       <= rd_data;
          beat_cnt <= '0;
          cur_last <= (ld_cnt == byte_count - 16'd1);
          ld_cnt   <= ld_cnt + 16'd1;
          m_tvalid <= 1'b1;
        end else if (hs) begin
          sh       <= is_bpsk ? {sh[6:0], 1'b0} : {sh[5:0], 2'b00};
          beat_cnt <= beat_cnt + 3'd1;
          if (last_beat) m_tvalid <= 1'b0;
        end
      end else begin
        rd_cnt   <= '0;
        ld_cnt   <= '0;
        rd_valid <= 1'b0;
        beat_cnt <= '0;
        m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_payload_serializer.sv
// Bench for payload_serializer (DEPTH=4): directed and random packets checked
// against a symbol-list model built from the packet bytes.
module tb_payload_serializer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready, s_tlast, s_tuser;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic [15:0] payload_length;
  logic        pkt_sent, overflow, busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] pkt_q[$];
  int         exp_q[$];

  payload_serializer #(.BYTES(1), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .payload_length(payload_length), .pkt_sent(pkt_sent),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int kept_bytes();
    return (pkt_q.size() > DEPTH) ? DEPTH : pkt_q.size();
  endfunction

  // Expected symbol stream: the first min(len, DEPTH) bytes, MSB first
  function automatic void build_expected(input bit bpsk);
    int b;
    exp_q.delete();
    for (int i = 0; i < kept_bytes(); i++) begin
      b = int'(pkt_q[i]);
      if (bpsk) for (int k = 7; k >= 0; k--) exp_q.push_back(((b >> k) & 1) != 0 ? 255 : 0);
      else      for (int k = 3; k >= 0; k--) exp_q.push_back((b >> (2 * k)) & 3);
    end
  endfunction

  task automatic apply_stimulus(input bit bpsk);
    for (int i = 0; i < pkt_q.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        tick();
      end
      s_tvalid = 1'b1;
      s_tdata  = pkt_q[i];
      s_tlast  = (i == pkt_q.size() - 1);
      s_tuser  = (i == 0) ? bpsk : 1'($urandom_range(0, 1));
      check_output("s_tready_fill", s_tready, 1);
      tick();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      if (i == 0) check_output("ovf_cleared", overflow, 0);
    end
  endtask

  // Called one cycle after the final input byte was accepted
  task automatic drain_packet(input bit bpsk, input int mode, input bit release_pkt);
    int i, cyc;
    bit stalled;
    logic [7:0] held_d;
    logic held_l;
    build_expected(bpsk);
    check_output("lat_c0", m_tvalid, 0);
    check_output("busy_drain", busy, 1);
    check_output("s_tready_drain", s_tready, 0);
    check_output("plen", payload_length, kept_bytes() * 8);
    tick();
    check_output("lat_c1", m_tvalid, 0);
    tick();
    check_output("lat_c2", m_tvalid, 1);
    i = 0; cyc = 0; stalled = 0;
    while (i < exp_q.size() && cyc < 400) begin
      m_tready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      pkt_sent = 1'($urandom_range(0, 1));
      if (stalled) begin
        check_output("stall_valid", m_tvalid, 1);
        check_output("stall_data", m_tdata, held_d);
        check_output("stall_last", m_tlast, held_l);
      end
      if (mode == 0) check_output("no_bubble", m_tvalid, 1);
      if (m_tvalid && m_tready) begin
        check_output("beat_data", m_tdata, exp_q[i]);
        check_output("beat_last", m_tlast, (i == exp_q.size() - 1));
        check_output("beat_user", m_tuser, bpsk);
        i++;
        stalled = 0;
      end else if (m_tvalid) begin
        stalled = 1;
        held_d  = m_tdata;
        held_l  = m_tlast;
      end
      tick();
      cyc++;
    end
    m_tready = 1'b0;
    pkt_sent = 1'b0;
    check_output("beats_done", i, exp_q.size());
    check_output("wait_valid", m_tvalid, 0);
    check_output("wait_last", m_tlast, 0);
    check_output("wait_busy", busy, 1);
    check_output("wait_ready", s_tready, 0);
    check_output("wait_ovf", overflow, pkt_q.size() > DEPTH);
    tick();
    tick();
    check_output("wait_hold_busy", busy, 1);
    check_output("wait_hold_plen", payload_length, kept_bytes() * 8);
    if (release_pkt) begin
      pkt_sent = 1'b1;
      tick();
      pkt_sent = 1'b0;
      check_output("release_busy", busy, 0);
      check_output("release_ready", s_tready, 1);
    end
  endtask

  initial begin
    int beats, cyc, len;
    bit bpsk;
    rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    m_tready = 1'b0; pkt_sent = 1'b0;
    repeat (3) tick();
    check_output("rst_s_tready", s_tready, 0);
    check_output("rst_m_tvalid", m_tvalid, 0);
    check_output("rst_m_tlast", m_tlast, 0);
    check_output("rst_m_tdata", m_tdata, 0);
    check_output("rst_m_tuser", m_tuser, 1);
    check_output("rst_plen", payload_length, 0);
    check_output("rst_ovf", overflow, 0);
    check_output("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    $display("[TB] BPSK two bytes, ready high");
    pkt_q = '{8'hA5, 8'h3C};
    apply_stimulus(1'b1);
    drain_packet(1'b1, 0, 1'b1);

    $display("[TB] QPSK single byte");
    pkt_q = '{8'hB4};
    apply_stimulus(1'b0);
    drain_packet(1'b0, 0, 1'b1);

    $display("[TB] BPSK two bytes, ready toggling");
    pkt_q = '{8'hA5, 8'h3C};
    apply_stimulus(1'b1);
    drain_packet(1'b1, 1, 1'b1);

    $display("[TB] exactly DEPTH bytes, QPSK, random ready");
    pkt_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    apply_stimulus(1'b0);
    drain_packet(1'b0, 2, 1'b1);

    $display("[TB] overflow: six bytes into DEPTH=4");
    pkt_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    apply_stimulus(1'b1);
    drain_packet(1'b1, 0, 1'b0);

    $display("[TB] next packet held off until pkt_sent");
    s_tvalid = 1'b1; s_tdata = 8'h5A; s_tlast = 1'b1; s_tuser = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_output("holdoff_ready", s_tready, 0);
      tick();
    end
    check_output("holdoff_ovf", overflow, 1);
    pkt_sent = 1'b1;
    tick();
    pkt_sent = 1'b0;
    check_output("idle_ready", s_tready, 1);
    check_output("idle_ovf_held", overflow, 1);
    check_output("idle_plen_held", payload_length, 32);
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    check_output("new_pkt_ovf", overflow, 0);
    pkt_q = '{8'h5A};
    drain_packet(1'b1, 0, 1'b1);

    $display("[TB] reset in the middle of a drain");
    pkt_q = '{8'hA5, 8'h3C};
    apply_stimulus(1'b1);
    m_tready = 1'b1;
    beats = 0; cyc = 0;
    while (beats < 4 && cyc < 40) begin
      if (m_tvalid) beats++;
      tick();
      cyc++;
    end
    check_output("pre_rst_beats", beats, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_tready = 1'b0;
    check_output("abort_valid", m_tvalid, 0);
    check_output("abort_last", m_tlast, 0);
    check_output("abort_plen", payload_length, 0);
    check_output("abort_busy", busy, 0);
    check_output("abort_user", m_tuser, 1);
    pkt_q = '{8'hC3, 8'h1E};
    apply_stimulus(1'b0);
    drain_packet(1'b0, 2, 1'b1);

    $display("[TB] random packets");
    for (int p = 0; p < 8; p++) begin
      len  = $urandom_range(1, 6);
      bpsk = 1'($urandom_range(0, 1));
      pkt_q.delete();
      for (int k = 0; k < len; k++) pkt_q.push_back(8'($urandom_range(0, 255)));
      apply_stimulus(bpsk);
      drain_packet(bpsk, $urandom_range(0, 2), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
